// File: rtl/fetcher_pingpong.sv
// Ping-pong operand tile buffer: the bus fills one LEN x LEN bank while
// the other streams one row or column per cycle into the skew stage.
module fetcher_pingpong #(
  parameter int LEN = 8,
  parameter int DW  = 16,
  parameter int AW  = (LEN > 1) ? $clog2(LEN) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              wvalid,
  output logic              wready,
  input  logic [AW-1:0]     waddr,
  input  logic [LEN*DW-1:0] wdata,
  input  logic              feed,
  input  logic              transpose,
  output logic [LEN*DW-1:0] data_out,
  output logic              data_valid,
  output logic [1:0]        bank_full
);

  typedef enum logic {S_IDLE, S_FEED} state_t;

  localparam logic [AW-1:0]  BLAST  = AW'(LEN - 1);
  localparam logic [AW:0]    LENW   = (AW + 1)'(LEN);
  localparam logic [LEN-1:0] BM_ALL = '1;

  state_t              r_state;
  state_t              w_next;
  logic [AW-1:0]       r_beat;
  logic                r_tmode;
  logic                r_rbank;
  logic                r_wbank;
  logic                r_pending;
  logic [1:0]          r_full;
  logic [LEN-1:0]      r_bm [2];
  logic [DW-1:0]       r_mem [2][LEN][LEN];
  logic [LEN*DW-1:0]   r_dout;
  logic                r_dvalid;

  logic                w_start;
  logic                w_last;
  logic                w_wr;
  logic                w_addr_ok;
  logic [LEN-1:0]      w_set;
  logic [LEN-1:0]      w_bm_new;
  logic [LEN*DW-1:0]   w_vec;

  assign wready     = ~r_full[r_wbank];
  assign data_out   = r_dout;
  assign data_valid = r_dvalid;
  assign bank_full  = r_full;

  // Out-of-range rows still complete the handshake but store nothing.
  assign w_addr_ok = ({1'b0, waddr} < LENW);
  assign w_wr      = cs & wvalid & wready & w_addr_ok;
  assign w_set     = LEN'(1) << waddr;
  assign w_bm_new  = r_bm[r_wbank] | w_set;

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_last  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if ((r_pending | feed) & r_full[r_rbank]) begin
          w_next  = S_FEED;
          w_start = 1'b1;
        end
      end
      S_FEED: begin
        if (r_beat == BLAST) begin
          w_last = 1'b1;
          if (r_pending & r_full[~r_rbank]) begin
            w_start = 1'b1;
          end else begin
            w_next = S_IDLE;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_vec = '0;
    for (int j = 0; j < LEN; j++) begin
      w_vec[j*DW +: DW] = r_tmode ? r_mem[r_rbank][j][r_beat]
                                  : r_mem[r_rbank][r_beat][j];
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      for (int j = 0; j < LEN; j++) begin
        r_mem[r_wbank][waddr][j] <= wdata[j*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_beat    <= '0;
      r_tmode   <= 1'b0;
      r_rbank   <= 1'b0;
      r_wbank   <= 1'b0;
      r_pending <= 1'b0;
      r_full    <= '0;
      r_bm[0]   <= '0;
      r_bm[1]   <= '0;
      r_dout    <= '0;
      r_dvalid  <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_dvalid <= (r_state == S_FEED);
      if (r_state == S_FEED) r_dout <= w_vec;

      if (w_start)   r_pending <= 1'b0;
      else if (feed) r_pending <= 1'b1;

      if (w_start) r_tmode <= transpose;

      if (w_start | w_last)       r_beat <= '0;
      else if (r_state == S_FEED) r_beat <= r_beat + 1'b1;

      // The bank being drained is full, so no write can target it here.
      if (w_last) begin
        r_full[r_rbank] <= 1'b0;
        r_bm[r_rbank]   <= '0;
        r_rbank         <= ~r_rbank;
      end

      if (w_wr) begin
        r_bm[r_wbank] <= w_bm_new;
        if (w_bm_new == BM_ALL) begin
          r_full[r_wbank] <= 1'b1;
          r_wbank         <= ~r_wbank;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetcher_pingpong.sv
// Directed/randomised bench for fetcher_pingpong against a tile-FIFO
// reference model of the expected output beats.
module tb_fetcher_pingpong;

  localparam int LEN = 8;
  localparam int DW  = 16;
  localparam int AW  = 3;
  localparam int VW  = LEN * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cs = 1'b0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [AW-1:0] waddr = '0;
  logic [VW-1:0] wdata = '0;
  logic          feed = 1'b0;
  logic          transpose = 1'b0;
  logic [VW-1:0] data_out;
  logic          data_valid;
  logic [1:0]    bank_full;

  always #5 clk = ~clk;

  fetcher_pingpong #(.LEN(LEN), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .wvalid(wvalid),
    .wready(wready), .waddr(waddr), .wdata(wdata),
    .feed(feed), .transpose(transpose), .data_out(data_out),
    .data_valid(data_valid), .bank_full(bank_full)
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [VW-1:0] got_v [$];
  int            got_c [$];
  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      got_v.push_back(data_out);
      got_c.push_back(cyc);
    end
  end

  logic [DW-1:0] pool [8][LEN][LEN];
  logic [VW-1:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [VW-1:0] obs,
                     input logic [VW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [VW-1:0] row_of(input int t, input int r);
    logic [VW-1:0] v;
    for (int j = 0; j < LEN; j++) v[j*DW +: DW] = pool[t][r][j];
    return v;
  endfunction

  task automatic fill(input int t, input bit rnd);
    for (int r = 0; r < LEN; r++)
      for (int c = 0; c < LEN; c++)
        pool[t][r][c] = rnd ? DW'($urandom) : DW'(r * 16 + c);
  endtask

  task automatic expect_tile(input int t, input bit tm);
    logic [VW-1:0] v;
    for (int k = 0; k < LEN; k++) begin
      for (int j = 0; j < LEN; j++)
        v[j*DW +: DW] = tm ? pool[t][j][k] : pool[t][k][j];
      exp_q.push_back(v);
    end
  endtask

  task automatic wr_row(input int r, input logic [VW-1:0] d);
    cs = 1'b1; wvalid = 1'b1; waddr = AW'(r); wdata = d;
    tick;
    cs = 1'b0; wvalid = 1'b0;
  endtask

  task automatic load(input int t);
    for (int r = 0; r < LEN; r++) wr_row(r, row_of(t, r));
  endtask

  task automatic pulse_feed(input bit tm, output int nf);
    feed = 1'b1; transpose = tm;
    tick;
    nf = cyc;
    feed = 1'b0; transpose = ~tm;
  endtask

  task automatic check_stream(input int nf, input string tag);
    chk({tag, " count"}, got_v.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_v.size(); k++) begin
      chk({tag, " data"}, got_v[k], exp_q[k]);
      chk({tag, " cycle"}, got_c[k], nf + 1 + k);
    end
    got_v.delete(); got_c.delete(); exp_q.delete();
  endtask

  initial begin
    int nf;
    int w;
    bit tm;
    repeat (2) tick;
    chk("rst valid", data_valid, 1'b0);
    chk("rst dout", data_out, {VW{1'b0}});
    chk("rst full", bank_full, 2'b00);
    chk("rst wready", wready, 1'b1);
    rst_n = 1'b1;
    tick;

    fill(0, 1'b0);
    load(0);
    chk("s1 full", bank_full, 2'b01);
    chk("s1 wready", wready, 1'b1);
    expect_tile(0, 1'b0);
    pulse_feed(1'b0, nf);
    repeat (LEN + 3) tick;
    check_stream(nf, "s1");
    chk("s1 drained", bank_full, 2'b00);

    load(0);
    chk("s2 full", bank_full, 2'b10);
    expect_tile(0, 1'b1);
    pulse_feed(1'b1, nf);
    repeat (LEN + 3) tick;
    check_stream(nf, "s2");

    fill(2, 1'b1);
    for (int r = 0; r < LEN; r++)
      for (int c = 0; c < LEN; c++)
        pool[3][r][c] = pool[2][r][c] + 16'h0100;
    load(2);
    expect_tile(2, 1'b0);
    expect_tile(3, 1'b0);
    transpose = 1'b0;
    for (int r = 0; r < LEN; r++) begin
      cs = 1'b1; wvalid = 1'b1;
      waddr = AW'(r); wdata = row_of(3, r);
      feed = (r == 0 || r == 3);
      tick;
      if (r == 0) nf = cyc;
    end
    cs = 1'b0; wvalid = 1'b0; feed = 1'b0;
    repeat (2 * LEN + 3) tick;
    check_stream(nf, "s3");

    fill(4, 1'b1);
    fill(5, 1'b1);
    load(4);
    load(5);
    chk("s4 full", bank_full, 2'b11);
    chk("s4 wready lo", wready, 1'b0);
    wr_row(0, {VW{1'b1}});
    tm = 1'($urandom);
    expect_tile(4, tm);
    pulse_feed(tm, nf);
    repeat (LEN - 1) tick;
    chk("s4 wready last", wready, 1'b0);
    tick;
    chk("s4 wready hi", wready, 1'b1);
    chk("s4 full after", bank_full, 2'b10);
    repeat (3) tick;
    check_stream(nf, "s4a");
    tm = 1'($urandom);
    expect_tile(5, tm);
    pulse_feed(tm, nf);
    repeat (LEN + 3) tick;
    check_stream(nf, "s4b");

    fill(6, 1'b1);
    tm = 1'($urandom);
    transpose = tm;
    feed = 1'b1;
    tick;
    feed = 1'b0;
    repeat (3) tick;
    chk("s5 idle", data_valid, 1'b0);
    load(6);
    w = cyc;
    expect_tile(6, tm);
    tick;
    chk("s5 w+1", data_valid, 1'b0);
    tick;
    chk("s5 w+2", data_valid, 1'b1);
    repeat (LEN + 2) tick;
    check_stream(w + 1, "s5");

    fill(7, 1'b1);
    for (int r = 0; r < 4; r++) wr_row(r, row_of(7, r));
    for (int c = 0; c < LEN; c++) pool[7][2][c] = 16'hAAAA;
    wr_row(2, row_of(7, 2));
    for (int r = 4; r < LEN; r++) wr_row(r, row_of(7, r));
    chk("s6 full", bank_full, 2'b10);
    expect_tile(7, 1'b0);
    pulse_feed(1'b0, nf);
    repeat (LEN + 3) tick;
    check_stream(nf, "s6");
    load(4);
    load(5);
    chk("s6 both", bank_full, 2'b11);
    expect_tile(4, 1'b0);
    while (exp_q.size() > 3) void'(exp_q.pop_back());
    pulse_feed(1'b0, nf);
    repeat (3) tick;
    rst_n = 1'b0;
    tick;
    chk("s6 rst valid", data_valid, 1'b0);
    chk("s6 rst full", bank_full, 2'b00);
    chk("s6 rst wready", wready, 1'b1);
    chk("s6 rst dout", data_out, {VW{1'b0}});
    rst_n = 1'b1;
    repeat (4) tick;
    check_stream(nf, "s6r");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetcher_pingpong.md
Name: fetcher_pingpong

Overview:
- Parametrised successor to the single-buffer matrix fetcher.
- Holds two LEN x LEN operand tiles (ping-pong banks) so the bus can load one tile while the other streams into the skew stage.
- Streams a tile one vector per cycle, as rows (normal) or columns (transpose), with a sticky feed request.
- Sits between the bus slave write port and the skew/systolic array input.

Parameters:
- LEN, 8, systolic array dimension: rows and columns per tile; beats per feed.
- DW, 16, width of one matrix element in bits.
- AW, $clog2(LEN), row address width (minimum 1).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk
- cs  in  1  chip select; a write needs cs=1
- wvalid  in  1  write data valid
- wready  out  1  fetcher can accept a row this cycle
- waddr  in  AW  row index within the current write bank
- wdata  in  LEN*DW  one row; element j is at bits [j*DW +: DW]
- feed  in  1  feed request pulse (level tolerated)
- transpose  in  1  feed mode, sampled when a feed starts: 0 = rows, 1 = columns
- data_out  out  LEN*DW  registered output vector; element j is at [j*DW +: DW]
- data_valid  out  1  data_out holds a valid beat
- bank_full  out  2  per-bank full flags (bit b = bank b holds a complete tile)

Behaviour:
- Reset (rst_n=0 at posedge):
  - Outputs: data_valid=0, data_out=0, bank_full=0, wready=1.
  - Internal: wbank=0, rbank=0, row bitmaps cleared, pending=0, state=IDLE.
  - Buffer contents are don't-care after reset.
  - Reset mid-feed aborts the feed: data_valid=0 on the next cycle and both banks are emptied.
- Write side:
  - wready=1 iff bank_full[wbank]=0 (combinational).
  - A write is accepted when cs & wvalid & wready. It stores wdata into bank[wbank] row waddr and sets bitmap[wbank][waddr].
  - Rewriting the same row overwrites the data; the bitmap is unchanged.
  - waddr>=LEN (non-power-of-2 LEN): handshake completes, nothing is stored, bitmap unchanged.
  - When the accepting write sets the last bitmap bit, bank_full[wbank] goes high the next cycle and wbank toggles on the same edge.
  - If the newly selected bank is still full, wready=0 until it is drained.
- Feed request:
  - pending is set on any cycle with feed=1 and cleared when a feed starts.
  - feed during FEED only sets pending, so back-to-back tiles queue.
- State machine:
  - IDLE: if (pending | feed) & bank_full[rbank], go to FEED. Latch transpose into tmode and set beat=0.
  - FEED: each cycle drive beat number beat with data_valid=1 and increment beat.
    - At beat=LEN-1: clear bank_full[rbank] and its bitmap, toggle rbank.
    - Then go to FEED again if pending & bank_full[other bank], otherwise go to IDLE.
    - This gives gapless back-to-back tiles.
- Output mapping (registered):
  - Row mode: beat k drives data_out element j = bank[rbank][k][j].
  - Column mode: beat k drives element j = bank[rbank][j][k].
  - Latency: with a full bank present, feed at posedge N puts beat 0 on data_valid/data_out after posedge N+1. The last beat is after posedge N+LEN.
  - data_out holds its last value when data_valid=0.
  - There is no back-pressure from skew; a feed of LEN beats is uninterruptible except by reset.
- Simultaneous events:
  - Bank clear at the last beat and a write into the same bank in the same cycle cannot happen, because wready=0 while that bank is full.
  - A write completing the tile in cycle N is visible to IDLE arbitration from cycle N+1.
  - feed with no full bank leaves pending set; the feed starts one cycle after the tile completes.
- Beat counter width is $clog2(LEN) and it wraps LEN-1 -> 0. Bank index is 1 bit and toggles.

Test Plan:
- Reset, then write rows 0..7 of bank 0 with element value (row*16+col), then pulse feed -> starting the cycle after feed, 8 valid beats with beat k element j = 16k+j. bank_full goes 01 -> 00 after the last beat.
- Same tile with transpose=1 at feed -> beat k element j = 16j+k, data_valid high for exactly 8 cycles.
- Load bank 0, start feed, and during the feed load bank 1 with values +0x100 and pulse feed again -> 16 contiguous valid beats, bank 0 data then bank 1 data, with no gap.
- Load both banks without feeding -> wready=0 and further writes are ignored. After one feed completes, wready returns to 1 on the cycle after the last beat.
- Pulse feed with both banks empty, then load a tile -> data_valid rises two cycles after the final row write (one cycle for full to register, one for the output register).
- Write rows 0..3, rewrite row 2 with 0xAAAA, write rows 4..7, feed -> row 2 outputs 0xAAAA. Then assert rst_n=0 at beat 3 of a subsequent feed -> data_valid=0 and bank_full=00 the next cycle.
